// File: rtl/pc_fetch_sequencer.sv
// PC fetch sequencer: IDLE -> FETCH -> EXEC loop that walks the program counter,
// resolves jumps/branches on retirement and halts on a misaligned next PC.
module pc_fetch_sequencer #(
    parameter int unsigned                DATA_BIT_WIDTH = 32,
    parameter logic [DATA_BIT_WIDTH-1:0]  RESET_PC       = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      imem_ready,
    output logic                      imem_req,
    output logic [DATA_BIT_WIDTH-1:0] pc,
    output logic [DATA_BIT_WIDTH-1:0] pc_plus4,
    output logic                      instr_valid,
    input  logic                      ex_done,
    input  logic                      is_jump,
    input  logic                      is_branch,
    input  logic                      cond_flag,
    input  logic [DATA_BIT_WIDTH-1:0] alu_result,
    input  logic [DATA_BIT_WIDTH-1:0] branch_offset,
    output logic [DATA_BIT_WIDTH-1:0] retire_cnt,
    output logic                      misalign_err
);

    localparam logic [DATA_BIT_WIDTH-1:0] PC_STEP  = DATA_BIT_WIDTH'(4);
    localparam logic [DATA_BIT_WIDTH-1:0] CNT_STEP = DATA_BIT_WIDTH'(1);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StExec,
        StHalt
    } state_e;

    state_e                    r_state;
    state_e                    w_state_next;
    logic [DATA_BIT_WIDTH-1:0] r_pc;
    logic [DATA_BIT_WIDTH-1:0] r_retire_cnt;
    logic                      r_misalign_err;

    logic [DATA_BIT_WIDTH-1:0] w_pc_plus4;
    logic [DATA_BIT_WIDTH-1:0] w_branch_target;
    logic [DATA_BIT_WIDTH-1:0] w_next_pc;
    logic                      w_retire;
    logic                      w_halt;

    // Sequential-PC and branch-target adders; both wrap at the datapath width.
    always_comb begin
        w_pc_plus4      = r_pc + PC_STEP;
        w_branch_target = w_pc_plus4 + (branch_offset << 2);
    end

    // Next-PC select: a jump overrides any branch, a taken branch beats fall-through.
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (is_jump) begin
            w_next_pc = alu_result;
        end else if (is_branch && cond_flag) begin
            w_next_pc = w_branch_target;
        end
    end

    // Next-state logic; retire or halt is decided only on the EXEC ex_done edge.
    always_comb begin
        w_state_next = r_state;
        w_retire     = 1'b0;
        w_halt       = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_state_next = StFetch;
            end
            StFetch: begin
                if (imem_ready) begin
                    w_state_next = StExec;
                end
            end
            StExec: begin
                if (ex_done) begin
                    if (w_next_pc[1:0] != 2'b00) begin
                        w_state_next = StHalt;
                        w_halt       = 1'b1;
                    end else begin
                        w_state_next = StFetch;
                        w_retire     = 1'b1;
                    end
                end
            end
            StHalt: begin
                w_state_next = StHalt;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // PC, retire counter and sticky misalignment flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc           <= RESET_PC;
            r_retire_cnt   <= '0;
            r_misalign_err <= 1'b0;
        end else begin
            if (w_retire) begin
                r_pc         <= w_next_pc;
                r_retire_cnt <= r_retire_cnt + CNT_STEP;
            end
            if (w_halt) begin
                r_misalign_err <= 1'b1;
            end
        end
    end

    // Handshake outputs depend on state alone, so they can never overlap.
    assign imem_req     = (r_state == StFetch);
    assign instr_valid  = (r_state == StExec);
    assign pc           = r_pc;
    assign pc_plus4     = w_pc_plus4;
    assign retire_cnt   = r_retire_cnt;
    assign misalign_err = r_misalign_err;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed scenarios plus random
// traffic, all compared against a behavioural model of the sequencer.
module tb_pc_fetch_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int PH_IDLE  = 0;
    localparam int PH_FETCH = 1;
    localparam int PH_EXEC  = 2;
    localparam int PH_HALT  = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_ready = 1'b0;
    logic        imem_req;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        ex_done = 1'b0;
    logic        is_jump = 1'b0;
    logic        is_branch = 1'b0;
    logic        cond_flag = 1'b0;
    logic [31:0] alu_result = '0;
    logic [31:0] branch_offset = '0;
    logic [31:0] retire_cnt;
    logic        misalign_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic        m_err;

    pc_fetch_sequencer #(
        .DATA_BIT_WIDTH (32),
        .RESET_PC       (RST_PC)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .imem_ready    (imem_ready),
        .imem_req      (imem_req),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .instr_valid   (instr_valid),
        .ex_done       (ex_done),
        .is_jump       (is_jump),
        .is_branch     (is_branch),
        .cond_flag     (cond_flag),
        .alu_result    (alu_result),
        .branch_offset (branch_offset),
        .retire_cnt    (retire_cnt),
        .misalign_err  (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check_eq("pc", pc, m_pc);
        check_eq("pc_plus4", pc_plus4, m_pc + 32'd4);
        check_eq("retire_cnt", retire_cnt, m_cnt);
        check_eq("misalign_err", {31'd0, misalign_err}, {31'd0, m_err});
        check_eq("imem_req", {31'd0, imem_req}, {31'd0, m_phase == PH_FETCH});
        check_eq("instr_valid", {31'd0, instr_valid}, {31'd0, m_phase == PH_EXEC});
    endtask

    // Advance the model by one clock using the inputs about to be sampled.
    task automatic model_edge();
        logic [31:0] nxt;
        case (m_phase)
            PH_IDLE:  m_phase = PH_FETCH;
            PH_FETCH: if (imem_ready) m_phase = PH_EXEC;
            PH_EXEC: begin
                if (ex_done) begin
                    if (is_jump)                     nxt = alu_result;
                    else if (is_branch && cond_flag) nxt = m_pc + 32'd4 + branch_offset * 32'd4;
                    else                             nxt = m_pc + 32'd4;
                    if (nxt % 4 != 0) begin
                        m_phase = PH_HALT;
                        m_err   = 1'b1;
                    end else begin
                        m_pc    = nxt;
                        m_cnt   = m_cnt + 32'd1;
                        m_phase = PH_FETCH;
                    end
                end
            end
            default: m_phase = PH_HALT;
        endcase
    endtask

    // Called at a falling edge with inputs already set; returns at the next falling edge.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
    endtask

    // Asynchronous reset pulse asserted between clock edges, checked before any edge.
    task automatic do_reset();
        #1 reset = 1'b1;
        #1;
        m_phase = PH_IDLE;
        m_pc    = RST_PC;
        m_cnt   = '0;
        m_err   = 1'b0;
        compare_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic set_in(input logic rdy, input logic done, input logic jmp, input logic br,
                          input logic cnd, input logic [31:0] alu, input logic [31:0] off);
        imem_ready    = rdy;
        ex_done       = done;
        is_jump       = jmp;
        is_branch     = br;
        cond_flag     = cnd;
        alu_result    = alu;
        branch_offset = off;
    endtask

    // From reset, retire two plain instructions and stop in EXEC at pc=8.
    task automatic goto_exec_pc8();
        do_reset();
        set_in(1, 1, 0, 0, 0, 32'h0, 32'h0);
        repeat (6) step();
        check_eq("pc8_setup_pc", pc, 32'h8);
        check_eq("pc8_setup_valid", {31'd0, instr_valid}, 32'd1);
    endtask

    initial begin
        m_phase = PH_IDLE;
        m_pc    = RST_PC;
        m_cnt   = '0;
        m_err   = 1'b0;
        @(negedge clk);

        // Straight-line fetch rhythm.
        do_reset();
        set_in(1, 1, 0, 0, 0, 32'h0, 32'h0);
        step();
        check_eq("idle_to_fetch", {31'd0, imem_req}, 32'd1);
        step();
        check_eq("seq_pc0", pc, 32'h0);
        step();
        check_eq("seq_pc4", pc, 32'h4);
        step();
        step();
        check_eq("seq_pc8", pc, 32'h8);
        step();
        step();
        check_eq("seq_cnt3", retire_cnt, 32'd3);

        // Backward taken branch and not-taken branch from pc=8.
        goto_exec_pc8();
        set_in(1, 1, 0, 1, 1, 32'h0, 32'hFFFF_FFFE);
        step();
        check_eq("branch_taken_pc", pc, 32'h4);
        goto_exec_pc8();
        set_in(1, 1, 0, 1, 0, 32'h0, 32'hFFFF_FFFE);
        step();
        check_eq("branch_not_taken_pc", pc, 32'hC);

        // Jump wins over a taken branch.
        do_reset();
        set_in(1, 0, 0, 0, 0, 32'h0, 32'h0);
        step();
        step();
        set_in(1, 1, 1, 1, 1, 32'h100, 32'h10);
        step();
        check_eq("jump_priority_pc", pc, 32'h100);

        // PC wrap at the top of the address space.
        set_in(1, 0, 0, 0, 0, 32'h0, 32'h0);
        step();
        set_in(1, 1, 1, 0, 0, 32'hFFFF_FFFC, 32'h0);
        step();
        check_eq("wrap_plus4", pc_plus4, 32'h0);
        set_in(1, 1, 0, 0, 0, 32'h0, 32'h0);
        step();
        step();
        check_eq("wrap_pc", pc, 32'h0);

        // Misaligned jump halts until reset.
        do_reset();
        set_in(1, 0, 0, 0, 0, 32'h0, 32'h0);
        step();
        step();
        set_in(1, 1, 1, 0, 0, 32'h102, 32'h0);
        step();
        check_eq("halt_err", {31'd0, misalign_err}, 32'd1);
        check_eq("halt_pc", pc, 32'h0);
        check_eq("halt_cnt", retire_cnt, 32'd0);
        set_in(1, 1, 0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("halt_no_req", {31'd0, imem_req}, 32'd0);
        end
        do_reset();
        check_eq("halt_cleared", {31'd0, misalign_err}, 32'd0);

        // Stalled fetch ignores ex_done.
        set_in(0, 1, 0, 0, 0, 32'h0, 32'h0);
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("stall_req", {31'd0, imem_req}, 32'd1);
            check_eq("stall_pc", pc, 32'h0);
        end
        set_in(1, 0, 0, 0, 0, 32'h0, 32'h0);
        step();
        check_eq("stall_release_valid", {31'd0, instr_valid}, 32'd1);

        // Asynchronous reset in the middle of EXEC at pc=0x20.
        do_reset();
        set_in(1, 0, 0, 0, 0, 32'h0, 32'h0);
        step();
        step();
        set_in(1, 1, 1, 0, 0, 32'h20, 32'h0);
        step();
        set_in(1, 0, 0, 0, 0, 32'h0, 32'h0);
        step();
        check_eq("midexec_pc_before", pc, 32'h20);
        check_eq("midexec_valid", {31'd0, instr_valid}, 32'd1);
        do_reset();
        check_eq("midexec_pc_after", pc, RST_PC);
        check_eq("midexec_cnt_after", retire_cnt, 32'd0);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            if ((m_phase == PH_HALT && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                logic [31:0] alu;
                int          off;
                alu = $urandom;
                if ($urandom_range(0, 7) != 0) alu[1:0] = 2'b00;
                off = int'($urandom_range(0, 64)) - 32;
                set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
                       1'($urandom_range(0, 1)), alu, off);
                step();
                check_eq("rand_excl", {31'd0, imem_req & instr_valid}, 32'd0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_sequencer.md
PC_FETCH_SEQUENCER -- requirements
Module: pc_fetch_sequencer

Interface
REQ-001 Parameter DATA_BIT_WIDTH, default 32, SHALL set the width of the PC, target, offset and counter datapaths.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be asynchronous, active-high; forces all state to reset values.
REQ-005 imem_ready  input  1  SHALL be high when instruction memory returns the word at pc this cycle.
REQ-006 imem_req  output  1  SHALL request an instruction fetch at address pc.
REQ-007 pc  output  DATA_BIT_WIDTH  SHALL be the current program counter.
REQ-008 pc_plus4  output  DATA_BIT_WIDTH  SHALL equal pc + 4 (modulo 2^32); used as the JAL link value.
REQ-009 instr_valid  output  1  SHALL be high while the fetched instruction is presented to the execute stage.
REQ-010 ex_done  input  1  SHALL be high when the execute stage (ALU) has finished the current instruction.
REQ-011 is_jump  input  1  SHALL mark the current instruction as an unconditional jump (JAL).
REQ-012 is_branch  input  1  SHALL mark the current instruction as a conditional branch.
REQ-013 cond_flag  input  1  SHALL be the ALU branch condition result.
REQ-014 alu_result  input  DATA_BIT_WIDTH  SHALL be the ALU output; used as the jump target.
REQ-015 branch_offset  input  DATA_BIT_WIDTH  SHALL be the sign-extended word offset of a branch.
REQ-016 retire_cnt  output  DATA_BIT_WIDTH  SHALL count retired instructions.
REQ-017 misalign_err  output  1  SHALL flag a sticky misaligned-next-PC halt.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, EXEC and HALT.
REQ-019 IDLE SHALL last exactly one clock after reset deasserts, then move to FETCH.
REQ-020 In FETCH, imem_req SHALL be 1 and the FSM SHALL stay until imem_ready is sampled 1, then move to EXEC.
REQ-021 In EXEC, instr_valid SHALL be 1 and the FSM SHALL stay until ex_done is sampled 1.
REQ-022 The next PC SHALL be alu_result when is_jump=1, regardless of is_branch.
REQ-023 With is_jump=0, is_branch=1 and cond_flag=1, the next PC SHALL be pc_plus4 + (branch_offset << 2), truncated to DATA_BIT_WIDTH.
REQ-024 In all other cases, the next PC SHALL be pc_plus4.
REQ-025 On the EXEC edge where ex_done=1, pc SHALL load the next PC, retire_cnt SHALL increment by 1, and the FSM SHALL move to FETCH.
REQ-026 If next PC[1:0] != 2'b00 on that edge, the FSM SHALL instead move to HALT.
- pc SHALL NOT update and retire_cnt SHALL NOT increment.
- misalign_err SHALL be set to 1.
REQ-027 HALT SHALL be exited only by reset; in HALT, imem_req=0 and instr_valid=0.
REQ-028 imem_ready outside FETCH and ex_done outside EXEC SHALL be ignored.
REQ-029 Arithmetic on pc, pc_plus4, the branch target and retire_cnt SHALL wrap modulo 2^DATA_BIT_WIDTH without error.
- Example: pc=32'hFFFF_FFFC gives pc_plus4=32'h0000_0000.
REQ-030 imem_req and instr_valid SHALL be Moore outputs decoded from state only.
- They SHALL never be high in the same cycle.
REQ-031 is_jump, is_branch, cond_flag, alu_result and branch_offset SHALL be sampled only on the ex_done edge.

Reset
REQ-032 Reset assertion SHALL immediately, without a clock edge, force:
- state=IDLE, pc=RESET_PC, retire_cnt=0, misalign_err=0
- imem_req=0, instr_valid=0
REQ-033 Reset asserted mid-FETCH or mid-EXEC SHALL abandon the instruction with no PC update and no count increment.

Verification
REQ-034 Reset release, imem_ready held 1, ex_done=1 on each EXEC cycle, no jump or branch -> pc sequence 0,4,8 with a 2-cycle FETCH/EXEC rhythm; retire_cnt=3 after the third ex_done.
REQ-035 pc=8, is_branch=1, cond_flag=1, branch_offset=32'hFFFF_FFFE -> next pc=4; same case with cond_flag=0 -> next pc=12.
REQ-036 is_jump=1 and is_branch=1, cond_flag=1, alu_result=32'h100 -> next pc=32'h100.
REQ-037 is_jump=1, alu_result=32'h102 -> HALT entered, misalign_err=1, pc unchanged, imem_req stays 0 for 10 cycles until reset.
REQ-038 imem_ready held 0 for 5 cycles in FETCH -> imem_req held 1, pc stable; ex_done pulses during FETCH ignored.
REQ-039 Reset asserted asynchronously mid-EXEC at pc=32'h20 -> pc=RESET_PC before the next clock edge; retire_cnt=0.
